// File: rtl/matrix_frame_loader.sv
// Packs a byte stream (two xRGB pixels per byte) into 32-bit row words and writes
// them to the 8x8 matrix driver's row registers 0..7 over pipelined Wishbone.
module matrix_frame_loader #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 3,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [7:0]                 i_data,
  input  logic                       i_sof,
  output logic                       o_ready,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic                       o_wb_we,
  output logic [WB_ADDR_WIDTH-1:0]   o_wb_addr,
  output logic [WB_DATA_WIDTH/8-1:0] o_wb_sel,
  output logic [WB_DATA_WIDTH-1:0]   o_wb_wdata,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_stall,
  output logic                       o_frame_done,
  output logic                       o_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int HW = WB_DATA_WIDTH - 8;

  typedef enum logic [1:0] {COLLECT, WRITE, WAIT_ACK} state_t;

  state_t             state;
  logic [WB_ADDR_WIDTH-1:0] row;
  logic [1:0]         byte_idx;
  logic [HW-1:0]      word_hi;  // bytes 0..2; byte 3 goes straight into o_wb_wdata
  logic [TW-1:0]      timer;
  logic               take;
  logic [1:0]         idx_eff;

  assign o_wb_we  = 1'b1;
  assign o_wb_sel = {(WB_DATA_WIDTH/8){1'b1}};
  assign take     = i_valid && o_ready;
  assign idx_eff  = i_sof ? 2'd0 : byte_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= COLLECT;
      row          <= '0;
      byte_idx     <= '0;
      word_hi      <= '0;
      timer        <= '0;
      o_ready      <= 1'b1;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_wdata   <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      case (state)
        COLLECT: begin
          if (take) begin
            if (idx_eff == 2'd3) begin
              o_wb_wdata <= {word_hi, i_data};
              o_wb_addr  <= row;
              byte_idx   <= 2'd0;
              o_ready    <= 1'b0;
              o_wb_cyc   <= 1'b1;
              o_wb_stb   <= 1'b1;
              state      <= WRITE;
            end else begin
              word_hi[HW-1 - 8*int'(idx_eff) -: 8] <= i_data;
              byte_idx <= idx_eff + 2'd1;
              if (i_sof) row <= '0;
            end
          end
        end
        WRITE: begin
          if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            timer    <= '0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Ack has priority over a timeout landing on the same edge
          if (i_wb_ack || timer == TW'(ACK_TIMEOUT - 1)) begin
            o_wb_cyc     <= 1'b0;
            o_ready      <= 1'b1;
            row          <= row + 1'b1;
            o_frame_done <= (row == '1);
            o_err        <= !i_wb_ack;
            state        <= COLLECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state    <= COLLECT;
          o_ready  <= 1'b1;
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Self-checking bench for matrix_frame_loader: byte-stream driver with a write
// scoreboard, a Wishbone slave responder and directed stall/timeout/reset cases.
module tb_matrix_frame_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_sof, i_wb_ack, i_wb_stall;
  logic [7:0]  i_data;
  logic        o_ready, o_wb_cyc, o_wb_stb, o_wb_we, o_frame_done, o_err;
  logic [2:0]  o_wb_addr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_wdata;

  matrix_frame_loader #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(3), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data), .i_sof(i_sof),
    .o_ready(o_ready), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_sel(o_wb_sel), .o_wb_wdata(o_wb_wdata),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int writes   = 0;
  bit ack_en   = 1'b1;
  logic [34:0] exp_q[$];

  // bench-side packing model
  logic [2:0]  m_row;
  logic [1:0]  m_idx;
  logic [31:0] m_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic model_reset();
    m_row = 3'd0; m_idx = 2'd0; m_word = 32'h0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof);
    bit ok = 1'b0;
    i_valid = 1'b1; i_data = d; i_sof = sof;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); ok = o_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    i_valid = 1'b0; i_sof = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    else begin
      if (sof) begin m_row = 3'd0; m_idx = 2'd0; end
      m_word = {m_word[23:0], d};
      if (m_idx == 2'd3) begin
        exp_q.push_back({m_row, m_word});
        m_row = m_row + 3'd1;
        m_idx = 2'd0;
      end else m_idx = m_idx + 2'd1;
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (o_ready && !o_wb_cyc) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (!ok) check("idle_timeout", 64'd0, 64'd1);
  endtask

  // Slave: ack in the cycle after the strobe is accepted
  initial begin
    bit acc;
    i_wb_ack = 1'b0;
    forever begin
      @(negedge clk);
      acc = o_wb_cyc && o_wb_stb && !i_wb_stall && ack_en && !reset;
      @(posedge clk); #1;
      i_wb_ack = acc;
    end
  end

  // Monitor: scoreboard compare on strobe acceptance, frame_done timing
  initial begin
    logic [34:0] e;
    bit pend_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) pend_done = 1'b0;
      else begin
        if (pend_done || o_frame_done) check("frame_done", o_frame_done, pend_done);
        if (o_frame_done) done_cnt++;
        if (o_err) err_cnt++;
        pend_done = o_wb_cyc && !o_wb_stb && i_wb_ack && (o_wb_addr == 3'd7);
        if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
          writes++;
          if (exp_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check("wb_addr", o_wb_addr, e[34:32]);
            check("wb_wdata", o_wb_wdata, e[31:0]);
            check("wb_sel", o_wb_sel, 4'hF);
            check("wb_we", o_wb_we, 1'b1);
          end
        end
      end
    end
  end

  initial begin
    int d0, w0, wcnt, e0, drained;
    logic [34:0] last;
    reset = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_sof = 1'b0; i_wb_stall = 1'b0;
    model_reset();
    tick(3);
    check("rst_cyc", o_wb_cyc, 1'b0);
    check("rst_stb", o_wb_stb, 1'b0);
    reset = 1'b0;
    tick(1);
    check("rst_ready", o_ready, 1'b1);
    check("rst_addr", o_wb_addr, 3'd0);
    check("rst_wdata", o_wb_wdata, 32'h0);
    check("rst_done", o_frame_done, 1'b0);
    check("rst_err", o_err, 1'b0);

    // Basic frame
    for (int i = 0; i < 32; i++) begin
      case (i % 4)
        0: send_byte(8'h12, i == 0);
        1: send_byte(8'h34, 1'b0);
        2: send_byte(8'h56, 1'b0);
        default: send_byte(8'h71, 1'b0);
      endcase
    end
    wait_idle(); tick(2);
    check("basic_writes", writes, 8);
    check("basic_done_cnt", done_cnt, 1);

    // Stall on row 2
    for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i), i == 0);
    wait_idle();
    i_wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + 17 * i), 1'b0);
    last = exp_q[exp_q.size() - 1];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_stb", o_wb_stb & o_wb_cyc, 1'b1);
      check("stall_addr", o_wb_addr, 3'd2);
      check("stall_wdata", o_wb_wdata, last[31:0]);
      check("stall_ready", o_ready, 1'b0);
      @(posedge clk); #1;
    end
    i_wb_stall = 1'b0;
    @(negedge clk);
    check("stall_release_stb", o_wb_stb, 1'b1);
    wait_idle();

    // Ack timeout on row 3
    e0 = err_cnt; w0 = writes;
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i), 1'b0);
    wcnt = 0; drained = 0;
    for (int k = 0; k < 60 && drained < 3; k++) begin
      @(negedge clk);
      if (o_wb_cyc && !o_wb_stb) wcnt++;
      if (!o_wb_cyc && wcnt > 0) drained++;
    end
    @(posedge clk); #1;
    ack_en = 1'b1;
    check("timeout_wait_cycles", wcnt, 15);
    check("timeout_err_pulses", err_cnt - e0, 1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), 1'b0);
    wait_idle();
    check("timeout_writes", writes - w0, 2);

    // Mid-row resync
    d0 = done_cnt;
    send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b0);
    send_byte(8'hEF, 1'b0); send_byte(8'h01, 1'b0);
    wait_idle(); tick(2);
    check("resync_no_done", done_cnt - d0, 0);

    // Backpressure then async reset while cyc is high
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
    i_valid = 1'b1; i_data = 8'h99;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready", o_ready, 1'b0);
      check("bp_cyc", o_wb_cyc, 1'b1);
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    check("async_rst_cyc", o_wb_cyc, 1'b0);
    check("async_rst_stb", o_wb_stb, 1'b0);
    i_valid = 1'b0;
    model_reset();
    ack_en = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    send_byte(8'h5A, 1'b0); send_byte(8'hA5, 1'b0);
    send_byte(8'h0F, 1'b0); send_byte(8'hF0, 1'b0);
    wait_idle();

    // Row wrap: 40 bytes, no sof
    reset = 1'b1; model_reset(); tick(2); reset = 1'b0; tick(1);
    d0 = done_cnt; w0 = writes;
    for (int i = 0; i < 40; i++) send_byte(8'(i * 7 + 3), 1'b0);
    wait_idle(); tick(2);
    check("wrap_writes", writes - w0, 10);
    check("wrap_done_cnt", done_cnt - d0, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
